// File: rtl/dp_pkg.sv
// Shared types and encodings for param_datapath: FSM states, ALU/shift/vsel codes, status bit positions.
package dp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_NOT = 3'd3;
  localparam logic [2:0] ALUOP_MUL = 3'd4;

  localparam logic [1:0] SHIFT_NONE = 2'd0;
  localparam logic [1:0] SHIFT_LSL  = 2'd1;
  localparam logic [1:0] SHIFT_LSR  = 2'd2;
  localparam logic [1:0] SHIFT_ASR  = 2'd3;

  localparam logic [1:0] VSEL_MDATA  = 2'd0;
  localparam logic [1:0] VSEL_SXIMM8 = 2'd1;
  localparam logic [1:0] VSEL_PC     = 2'd2;
  localparam logic [1:0] VSEL_C      = 2'd3;

  localparam int STATUS_V = 2;
  localparam int STATUS_N = 1;
  localparam int STATUS_Z = 0;

endpackage

// File: rtl/param_datapath_if.sv
// Command/result bundle between the decoder (master) and param_datapath (slave).
interface param_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 9
);
  localparam int RA_W = $clog2(NREGS);

  logic             start;
  logic             mode;
  logic [RA_W-1:0]  readnum_a;
  logic [RA_W-1:0]  readnum_b;
  logic [RA_W-1:0]  writenum;
  logic             write;
  logic             loads;
  logic [1:0]       vsel;
  logic [1:0]       shift;
  logic             asel;
  logic             bsel;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] mdata;
  logic [WIDTH-1:0] sximm8;
  logic [WIDTH-1:0] sximm5;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] datapath_out;
  logic [2:0]       status;
  logic [WIDTH-1:0] data_out;

  modport master (
    output start, mode, readnum_a, readnum_b, writenum, write, loads, vsel, shift,
           asel, bsel, aluop, mdata, sximm8, sximm5, pc,
    input  busy, done, datapath_out, status, data_out
  );

  modport slave (
    input  start, mode, readnum_a, readnum_b, writenum, write, loads, vsel, shift,
           asel, bsel, aluop, mdata, sximm8, sximm5, pc,
    output busy, done, datapath_out, status, data_out
  );
endinterface

// File: rtl/dp_regfile.sv
// Register array with async clear, one synchronous write port and one combinational read port.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RA_W-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RA_W-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (int'(waddr) < NREGS)) begin
      regs[waddr] <= wdata;
    end
  end

  // Addresses past NREGS (non power-of-two counts) read as zero.
  assign rdata = (int'(raddr) < NREGS) ? regs[raddr] : '0;
endmodule

// File: rtl/param_datapath.sv
// Self-sequencing datapath: one command per start/done, RDA->RDB->EXEC->WB (ALU) or WB only (MOV).
// Define DP_MUL_EN to add an unsigned multiply on aluop=4; otherwise aluop[2] is ignored.
module param_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 9
) (
  input logic             clk,
  input logic             reset,
  param_datapath_if.slave bus
);
  localparam int RA_W = $clog2(NREGS);

  state_e           state;
  logic             busy_q, done_q;
  logic [RA_W-1:0]  ra_q, rb_q, wn_q;
  logic             wr_q, ld_q, asel_q, bsel_q;
  logic [1:0]       vsel_q, shift_q;
  logic [2:0]       aluop_q;
  logic [WIDTH-1:0] mdata_q, sximm8_q, sximm5_q;
  logic [PC_W-1:0]  pc_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       status_q;

  logic [RA_W-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_dat, wb_dat, b_sh, ain, bin, res;
  logic [2:0]       op_eff, flags;
  logic             ovf, wb_en;

  assign rd_addr = (state == RDA) ? ra_q : rb_q;
  assign wb_en   = (state == WB) && wr_q;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wb_en),
    .waddr (wn_q),
    .wdata (wb_dat),
    .raddr (rd_addr),
    .rdata (rd_dat)
  );

  always_comb begin
    wb_dat = c_q;
    case (vsel_q)
      VSEL_MDATA:  wb_dat = mdata_q;
      VSEL_SXIMM8: wb_dat = sximm8_q;
      VSEL_PC:     wb_dat = WIDTH'(pc_q);
      default:     wb_dat = c_q;
    endcase
  end

  always_comb begin
    b_sh = b_q;
    case (shift_q)
      SHIFT_LSL: b_sh = {b_q[WIDTH-2:0], 1'b0};
      SHIFT_LSR: b_sh = {1'b0, b_q[WIDTH-1:1]};
      SHIFT_ASR: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default:   b_sh = b_q;
    endcase
  end

  assign ain = asel_q ? '0 : a_q;
  assign bin = bsel_q ? sximm5_q : b_sh;

`ifdef DP_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod   = {{WIDTH{1'b0}}, ain} * {{WIDTH{1'b0}}, bin};
  assign op_eff = (aluop_q == ALUOP_MUL) ? ALUOP_MUL : (aluop_q & 3'b011);
`else
  assign op_eff = aluop_q & 3'b011;
`endif

  // Overflow only when operands (after SUB's negation) share a sign the result lacks.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_eff)
      ALUOP_ADD: begin
        res = ain + bin;
        ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALUOP_SUB: begin
        res = ain - bin;
        ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      ALUOP_AND: res = ain & bin;
      ALUOP_NOT: res = ~bin;
`ifdef DP_MUL_EN
      ALUOP_MUL: begin
        res = prod[WIDTH-1:0];
        ovf = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: res = '0;
    endcase
  end

  always_comb begin
    flags           = '0;
    flags[STATUS_V] = ovf;
    flags[STATUS_N] = res[WIDTH-1];
    flags[STATUS_Z] = (res == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      wn_q     <= '0;
      wr_q     <= 1'b0;
      ld_q     <= 1'b0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      vsel_q   <= '0;
      shift_q  <= '0;
      aluop_q  <= '0;
      mdata_q  <= '0;
      sximm8_q <= '0;
      sximm5_q <= '0;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra_q     <= bus.readnum_a;
            rb_q     <= bus.readnum_b;
            wn_q     <= bus.writenum;
            wr_q     <= bus.write;
            ld_q     <= bus.loads;
            asel_q   <= bus.asel;
            bsel_q   <= bus.bsel;
            vsel_q   <= bus.vsel;
            shift_q  <= bus.shift;
            aluop_q  <= bus.aluop;
            mdata_q  <= bus.mdata;
            sximm8_q <= bus.sximm8;
            sximm5_q <= bus.sximm5;
            pc_q     <= bus.pc;
            busy_q   <= 1'b1;
            state    <= bus.mode ? WB : RDA;
          end
        end
        RDA: begin
          a_q   <= rd_dat;
          state <= RDB;
        end
        RDB: begin
          b_q   <= rd_dat;
          state <= EXEC;
        end
        EXEC: begin
          c_q <= res;
          if (ld_q) status_q <= flags;
          state <= WB;
        end
        WB: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.datapath_out = c_q;
  assign bus.status       = status_q;
  assign bus.data_out     = rd_dat;
endmodule

// File: tb/tb_param_datapath.sv
// Directed self-checking bench for param_datapath (default parameters, with or without DP_MUL_EN).
module tb_param_datapath;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int PC_W  = 9;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  param_datapath_if #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_W(PC_W)) bus ();

  param_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic m, input int ra, input int rb, input int wn,
                         input logic wr, input logic ld, input logic [1:0] vs,
                         input logic [1:0] sh, input logic a_sel, input logic b_sel,
                         input logic [2:0] op, input logic [15:0] md, input logic [15:0] s8,
                         input logic [15:0] s5, input logic [8:0] pcv);
    bus.mode      = m;
    bus.readnum_a = 3'(ra);
    bus.readnum_b = 3'(rb);
    bus.writenum  = 3'(wn);
    bus.write     = wr;
    bus.loads     = ld;
    bus.vsel      = vs;
    bus.shift     = sh;
    bus.asel      = a_sel;
    bus.bsel      = b_sel;
    bus.aluop     = op;
    bus.mdata     = md;
    bus.sximm8    = s8;
    bus.sximm5    = s5;
    bus.pc        = pcv;
  endtask

  // Called at a negedge; returns cycles from the start cycle to the done cycle (0 = timeout).
  task automatic go(output int lat, output logic b1);
    lat = 0;
    b1  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) b1 = bus.busy;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mov(input int wn, input logic [1:0] vs, input logic [15:0] md,
                     input logic [15:0] s8, input logic [8:0] pcv,
                     output int lat, output logic b1);
    set_cmd(1'b1, 0, 0, wn, 1'b1, 1'b0, vs, 2'd0, 1'b0, 1'b0, 3'd0, md, s8, 16'h0, pcv);
    go(lat, b1);
  endtask

  task automatic alu(input int ra, input int rb, input int wn, input logic [1:0] sh,
                     input logic a_sel, input logic b_sel, input logic [2:0] op,
                     input logic [15:0] s5, input logic ld, output int lat, output logic b1);
    set_cmd(1'b0, ra, rb, wn, 1'b1, ld, 2'd3, sh, a_sel, b_sel, op, 16'h0, 16'h0, s5, 9'h0);
    go(lat, b1);
  endtask

  // Non-writing MOV whose readnum_b selects r; data_out shows R[r] once back in IDLE.
  task automatic peek(input int r, output logic [15:0] val);
    int   lat;
    logic b1;
    set_cmd(1'b1, 0, r, 0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 9'h0);
    go(lat, b1);
    val = bus.data_out;
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic        b1;
    logic [15:0] v;

    reset     = 1'b1;
    bus.start = 1'b0;
    set_cmd(1'b0, 0, 0, 0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 9'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_c", 32'(bus.datapath_out), 32'h0);
    chk("rst_status", 32'(bus.status), 32'h0);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // MOV immediate into R0
    mov(0, 2'd1, 16'h0000, 16'h0007, 9'h0, lat, b1);
    chk("mov_latency", 32'(lat), 32'd2);
    chk("mov_busy", 32'(b1), 32'h1);
    peek(0, v);
    chk("mov_r0", 32'(v), 32'h0007);
    chk("mov_status", 32'(bus.status), 32'h0);
    mov(1, 2'd1, 16'h0000, 16'h0002, 9'h0, lat, b1);

    // R2 = R0 + (R1 << 1) = 7 + 4
    alu(0, 1, 2, 2'd1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, lat, b1);
    chk("add_latency", 32'(lat), 32'd5);
    chk("add_busy", 32'(b1), 32'h1);
    chk("add_c", 32'(bus.datapath_out), 32'h000B);
    chk("add_status", 32'(bus.status), 32'h0);
    peek(2, v);
    chk("add_r2", 32'(v), 32'h000B);

    mov(3, 2'd1, 16'h0000, 16'h7FFF, 9'h0, lat, b1);
    mov(4, 2'd1, 16'h0000, 16'h0001, 9'h0, lat, b1);
    alu(3, 4, 5, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, lat, b1);
    chk("add_ovf_c", 32'(bus.datapath_out), 32'h8000);
    chk("add_ovf_status", 32'(bus.status), 32'b110);
    alu(4, 4, 6, 2'd0, 1'b0, 1'b0, 3'd1, 16'h0, 1'b1, lat, b1);
    chk("sub_zero_c", 32'(bus.datapath_out), 32'h0000);
    chk("sub_zero_status", 32'(bus.status), 32'b001);

    // 0 + (0x8000 LSR 1) with loads=0 keeps the previous status
    alu(0, 5, 7, 2'd2, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, lat, b1);
    chk("lsr_c", 32'(bus.datapath_out), 32'h4000);
    chk("noload_status", 32'(bus.status), 32'b001);
    alu(5, 4, 6, 2'd0, 1'b0, 1'b0, 3'd1, 16'h0, 1'b1, lat, b1);
    chk("sub_ovf_c", 32'(bus.datapath_out), 32'h7FFF);
    chk("sub_ovf_status", 32'(bus.status), 32'b100);
    alu(3, 0, 7, 2'd0, 1'b0, 1'b1, 3'd2, 16'h00F0, 1'b1, lat, b1);
    chk("and_imm_c", 32'(bus.datapath_out), 32'h00F0);
    chk("and_imm_status", 32'(bus.status), 32'b000);
    alu(0, 5, 7, 2'd3, 1'b0, 1'b0, 3'd3, 16'h0, 1'b1, lat, b1);
    chk("not_asr_c", 32'(bus.datapath_out), 32'h3FFF);
    peek(7, v);
    chk("not_asr_r7", 32'(v), 32'h3FFF);

    mov(7, 2'd2, 16'h0000, 16'h0000, 9'h1A5, lat, b1);
    peek(7, v);
    chk("mov_pc_r7", 32'(v), 32'h01A5);
    mov(6, 2'd0, 16'hBEEF, 16'h1234, 9'h0, lat, b1);
    peek(6, v);
    chk("mov_mdata_r6", 32'(v), 32'hBEEF);

    // start held high through the busy window: one command only, captured fields frozen
    set_cmd(1'b0, 0, 1, 2, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 9'h0);
    ndone = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 set_cmd(1'b1, 0, 0, 0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 3'd0, 16'h0, 16'hDEAD, 16'h0, 9'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (k == 4) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
    chk("held_start_dones", 32'(ndone), 32'd1);
    peek(2, v);
    chk("held_start_r2", 32'(v), 32'h0009);
    peek(0, v);
    chk("held_start_r0", 32'(v), 32'h0007);

    // reset during EXEC aborts the write of 5 into R7
    set_cmd(1'b0, 0, 0, 7, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 3'd0, 16'h0, 16'h0, 16'h0005, 9'h0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_c", 32'(bus.datapath_out), 32'h0);
    peek(7, v);
    chk("abort_r7", 32'(v), 32'h0000);
    peek(0, v);
    chk("abort_r0_cleared", 32'(v), 32'h0000);

    // aluop=4 on 0x0100 and 0x0100
    mov(5, 2'd1, 16'h0000, 16'h0100, 9'h0, lat, b1);
    mov(6, 2'd1, 16'h0000, 16'h0100, 9'h0, lat, b1);
    alu(5, 6, 7, 2'd0, 1'b0, 1'b0, 3'd4, 16'h0, 1'b1, lat, b1);
    chk("op4_latency", 32'(lat), 32'd5);
`ifdef DP_MUL_EN
    chk("mul_c", 32'(bus.datapath_out), 32'h0000);
    chk("mul_status", 32'(bus.status), 32'b101);
`else
    chk("op4_add_c", 32'(bus.datapath_out), 32'h0200);
    chk("op4_add_status", 32'(bus.status), 32'b000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
